// File: rtl/controller_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
package controller_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBranch,
        StUnknown
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       aluop;
        logic       regw;
        logic       memw;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.irwrite   = 1'b1;
                c.nextpc    = 1'b1;
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            StDecode: begin
                c.alusrca   = 2'b01;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            StExecuteR: c.aluop = 1'b1;
            StExecuteI: begin
                c.aluop   = 1'b1;
                c.alusrcb = 2'b01;
            end
            StMemAdr: c.alusrcb = 2'b01;
            StMemRd:  c.adrsrc  = 1'b1;
            StMemWr: begin
                c.adrsrc = 1'b1;
                c.memw   = 1'b1;
            end
            StMemWb: begin
                c.resultsrc = 2'b01;
                c.regw      = 1'b1;
            end
            StAluWb: c.regw = 1'b1;
            StBranch: begin
                c.branch    = 1'b1;
                c.alusrcb   = 2'b01;
                c.resultsrc = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/controller_if.sv
// Control/status bundle between the controller and the multicycle datapath.
interface controller_if;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite;
    logic         MemWrite;
    logic         RegWrite;
    logic         IRWrite;
    logic         AdrSrc;
    logic [1:0]   RegSrc;
    logic [1:0]   ImmSrc;
    logic [1:0]   ALUSrcA;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ResultSrc;
    logic [1:0]   ALUControl;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl
    );
endinterface

// File: rtl/cond_logic.sv
// Held NZCV flags, condition evaluation and gating of the architectural write enables.
module cond_logic
    import controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       next_pc,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write
);
    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       cond_ex;
    logic       cond_ex_q;
    logic       n, z, c, v;

    assign {n, z} = nz_q;
    assign {c, v} = cv_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // cond_ex_q carries the decision taken in DECODE/EXECUTE into the write cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            nz_q      <= 2'b00;
            cv_q      <= 2'b00;
            cond_ex_q <= 1'b0;
        end else begin
            cond_ex_q <= cond_ex;
            if (flag_w[1] & cond_ex) nz_q <= alu_flags[3:2];
            if (flag_w[0] & cond_ex) cv_q <= alu_flags[1:0];
        end
    end

    assign reg_write = reg_w & cond_ex_q;
    assign mem_write = mem_w & cond_ex_q;
    assign pc_write  = (pcs & cond_ex_q) | next_pc;
endmodule

// File: rtl/controller.sv
// Multicycle controller: instruction decode, FSM with registered controls, ALU decode.
// Optional CONTROLLER_CMP_EN adds CMP (Funct[4:1]=1010) with writeback suppressed.
module controller
    import controller_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    controller_if.master  bus
);
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cond;
    logic       is_cmp;
    logic       unused_rn;

    assign cond      = bus.Instr[31:28];
    assign op        = bus.Instr[27:26];
    assign funct     = bus.Instr[25:20];
    assign rd        = bus.Instr[15:12];
    assign unused_rn = ^bus.Instr[19:16];

`ifdef CONTROLLER_CMP_EN
    assign is_cmp = (op == OP_DP) && (funct[4:1] == 4'b1010);
`else
    assign is_cmp = 1'b0;
`endif

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_DP:   state_d = funct[5] ? StExecuteI : StExecuteR;
                    OP_MEM:  state_d = StMemAdr;
                    OP_BR:   state_d = StBranch;
                    default: state_d = StUnknown;
                endcase
            end
            StMemAdr:   state_d = funct[0] ? StMemRd : StMemWr;
            StMemRd:    state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        ctrl_d = state_ctrl(state_d);
        if ((state_d == StAluWb) && is_cmp) ctrl_d.regw = 1'b0;
    end

    // Controls are registered alongside the state so they are glitch-free in each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            ctrl_q  <= state_ctrl(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    logic [1:0] alu_control;
    logic [1:0] flag_w;

    always_comb begin
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        if (ctrl_q.aluop) begin
            case (funct[4:1])
                4'b0100: alu_control = ALU_ADD;
                4'b0010: alu_control = ALU_SUB;
                4'b0000: alu_control = ALU_AND;
                4'b1100: alu_control = ALU_ORR;
                default: alu_control = ALU_ADD;
            endcase
            flag_w[1] = funct[0];
            flag_w[0] = funct[0] & ((alu_control == ALU_ADD) || (alu_control == ALU_SUB));
            if (is_cmp) begin
                alu_control = ALU_SUB;
                flag_w      = 2'b11;
            end
        end
    end

    logic pcs;
    assign pcs = ((rd == 4'hF) & ctrl_q.regw) | ctrl_q.branch;

    cond_logic u_cond_logic (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (bus.ALUFlags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (ctrl_q.regw),
        .mem_w     (ctrl_q.memw),
        .next_pc   (ctrl_q.nextpc),
        .pc_write  (bus.PCWrite),
        .reg_write (bus.RegWrite),
        .mem_write (bus.MemWrite)
    );

    assign bus.IRWrite    = ctrl_q.irwrite;
    assign bus.AdrSrc     = ctrl_q.adrsrc;
    assign bus.ALUSrcA    = ctrl_q.alusrca;
    assign bus.ALUSrcB    = ctrl_q.alusrcb;
    assign bus.ResultSrc  = ctrl_q.resultsrc;
    assign bus.ALUControl = alu_control;
    assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
    assign bus.ImmSrc     = op;
endmodule

// File: tb/tb_controller.sv
// Randomized bench for controller: per-cycle comparison against a phase-level model.
module tb_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    controller_if bus ();

    controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcw, memw, regw, irw, adr;
        logic [1:0] rsrc, isrc, sa, sb, res, aluc;
    } vec_t;

    typedef enum {PhFetch, PhDecode, PhExecR, PhExecI, PhAluWb, PhMemAdr, PhMemRd,
                  PhMemWb, PhMemWr, PhBranch, PhUnknown} ph_e;

    vec_t  dut_vec, exp_vec;
    vec_t  trace [0:7];
    string ph_name = "none";
    logic  chk_en = 1'b0;
    logic [3:0] flags_m;
    int    n_cmp = 0;
    int    n_fail = 0;

    assign dut_vec = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
                      bus.RegSrc, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                      bus.ALUControl};

    function automatic logic is_cmp(logic [19:0] ins);
`ifdef CONTROLLER_CMP_EN
        return (ins[15:14] == 2'b00) && (ins[12:9] == 4'b1010);
`else
        return (ins[19:0] != ins[19:0]);
`endif
    endfunction

    function automatic logic [1:0] alu_fn(logic [19:0] ins);
        if (is_cmp(ins)) return 2'b01;
        case (ins[12:9])
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic cond_ok(logic [3:0] cc, logic [3:0] fl);
        logic n, z, c, v;
        {n, z, c, v} = fl;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // k-th cycle of an instruction, k=0 being its FETCH; PhFetch again once complete.
    function automatic ph_e phase_at(logic [19:0] ins, int k);
        logic [1:0] op;
        op = ins[15:14];
        if (k == 0) return PhFetch;
        if (k == 1) return PhDecode;
        case (op)
            2'b00: begin
                if (k == 2) return ins[13] ? PhExecI : PhExecR;
                if (k == 3) return PhAluWb;
            end
            2'b01: begin
                if (k == 2) return PhMemAdr;
                if (k == 3) return ins[8] ? PhMemRd : PhMemWr;
                if (k == 4 && ins[8]) return PhMemWb;
            end
            2'b10:   if (k == 2) return PhBranch;
            default: if (k == 2) return PhUnknown;
        endcase
        return PhFetch;
    endfunction

    function automatic vec_t expect_vec(ph_e ph, logic [19:0] ins, logic pass);
        vec_t v;
        logic rd15, wb;
        v = '0;
        rd15 = (ins[3:0] == 4'hF);
        v.rsrc = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
        v.isrc = ins[15:14];
        case (ph)
            PhFetch: begin
                v.irw = 1'b1; v.pcw = 1'b1; v.sa = 2'b01; v.sb = 2'b10; v.res = 2'b10;
            end
            PhDecode: begin
                v.sa = 2'b01; v.sb = 2'b10; v.res = 2'b10;
            end
            PhExecR:  v.aluc = alu_fn(ins);
            PhExecI: begin
                v.aluc = alu_fn(ins); v.sb = 2'b01;
            end
            PhAluWb: begin
                wb = pass && !is_cmp(ins);
                v.regw = wb; v.pcw = wb && rd15;
            end
            PhMemAdr: v.sb = 2'b01;
            PhMemRd:  v.adr = 1'b1;
            PhMemWb: begin
                v.res = 2'b01; v.regw = pass; v.pcw = pass && rd15;
            end
            PhMemWr: begin
                v.adr = 1'b1; v.memw = pass;
            end
            PhBranch: begin
                v.sb = 2'b01; v.res = 2'b10; v.pcw = pass;
            end
            default: v = v;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cycle %s: got %05h expected %05h (instr %05h)",
                         ph_name, dut_vec, exp_vec, bus.Instr);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Entered during a FETCH cycle; returns during the following FETCH cycle.
    task automatic run_instr(input logic [19:0] ins, input logic use_dir,
                             input logic [3:0] dir_fl, output int lat);
        logic       pass, is_ex;
        logic [3:0] af;
        ph_e        ph;
        int         k;
        for (int i = 0; i < 8; i++) trace[i] = '0;
        @(posedge clk); #1;
        bus.Instr = ins;
        pass = cond_ok(ins[19:16], flags_m);
        k = 1;
        ph = phase_at(ins, k);
        while (ph != PhFetch && k < 7) begin
            is_ex = (ph == PhExecR) || (ph == PhExecI);
            af = (use_dir && is_ex) ? dir_fl : 4'($urandom);
            bus.ALUFlags = af;
            exp_vec = expect_vec(ph, ins, pass);
            ph_name = ph.name();
            @(negedge clk);
            trace[k] = dut_vec;
            @(posedge clk);
            if (is_ex && pass) begin
                if (ins[8] || is_cmp(ins)) flags_m[3:2] = af[3:2];
                if ((ins[8] && alu_fn(ins) <= 2'b01) || is_cmp(ins)) flags_m[1:0] = af[1:0];
            end
            #1;
            k++;
            ph = phase_at(ins, k);
        end
        exp_vec = expect_vec(PhFetch, ins, pass);
        ph_name = "PhFetch";
        bus.ALUFlags = 4'($urandom);
        @(negedge clk);
        trace[k] = dut_vec;
        lat = 0;
        for (int i = 1; i < 8; i++) if (lat == 0 && trace[i].irw) lat = i;
    endtask

    initial begin
        int lat;
        logic [19:0] ins;
        reset = 1'b1;
        bus.Instr = '0;
        bus.ALUFlags = '0;
        flags_m = 4'h0;
        @(posedge clk); #1;
        exp_vec = expect_vec(PhFetch, 20'h0, 1'b0);
        ph_name = "reset";
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_irwrite", int'(bus.IRWrite), 1);
        chk("reset_pcwrite", int'(bus.PCWrite), 1);
        chk("reset_regwrite", int'(bus.RegWrite), 0);
        chk("reset_memwrite", int'(bus.MemWrite), 0);
        chk("reset_alusrca", int'(bus.ALUSrcA), 1);
        chk("reset_alusrcb", int'(bus.ALUSrcB), 2);
        chk("reset_resultsrc", int'(bus.ResultSrc), 2);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(20'hE0802, 1'b1, 4'h0, lat);
        chk("add_latency", lat, 4);
        chk("add_exec_alusrcb", int'(trace[2].sb), 0);
        chk("add_exec_aluctl", int'(trace[2].aluc), 0);
        chk("add_wb_regwrite", int'(trace[3].regw), 1);

        run_instr(20'hE2523, 1'b1, 4'b0100, lat);
        chk("subs_exec_aluctl", int'(trace[2].aluc), 1);
        chk("subs_exec_alusrcb", int'(trace[2].sb), 1);

        run_instr(20'h0A000, 1'b0, 4'h0, lat);
        chk("beq_latency", lat, 3);
        chk("beq_pcwrite", int'(trace[2].pcw), 1);

        run_instr(20'h1A000, 1'b0, 4'h0, lat);
        chk("bne_pcwrite", int'(trace[2].pcw), 0);

        run_instr(20'hE5901, 1'b0, 4'h0, lat);
        chk("ldr_latency", lat, 5);
        chk("ldr_memrd_adrsrc", int'(trace[3].adr), 1);
        chk("ldr_memwb_resultsrc", int'(trace[4].res), 1);
        chk("ldr_memwb_regwrite", int'(trace[4].regw), 1);

        run_instr(20'hE5801, 1'b0, 4'h0, lat);
        chk("str_latency", lat, 4);
        chk("str_memwrite", int'(trace[3].memw), 1);

        run_instr(20'h10802, 1'b0, 4'h0, lat);
        chk("addne_fail_regwrite", int'(trace[3].regw), 0);

        run_instr(20'hE080F, 1'b0, 4'h0, lat);
        chk("add_pc_pcwrite", int'(trace[3].pcw), 1);

        run_instr(20'hEC000, 1'b0, 4'h0, lat);
        chk("unknown_latency", lat, 3);
        chk("unknown_writes", int'({trace[2].pcw, trace[2].regw, trace[2].memw}), 0);

        // Reset in the middle of an LDR.
        @(posedge clk); #1;
        bus.Instr = 20'hE5901;
        exp_vec = expect_vec(PhDecode, 20'hE5901, 1'b1);
        ph_name = "mid_decode";
        @(posedge clk); #1;
        exp_vec = expect_vec(PhMemAdr, 20'hE5901, 1'b1);
        ph_name = "mid_memadr";
        reset = 1'b1;
        @(posedge clk); #1;
        flags_m = 4'h0;
        exp_vec = expect_vec(PhFetch, 20'hE5901, 1'b1);
        ph_name = "mid_reset_fetch";
        @(negedge clk);
        chk("midreset_irwrite", int'(bus.IRWrite), 1);
        chk("midreset_adrsrc", int'(bus.AdrSrc), 0);
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 1) == 0) ins[19:16] = 4'hE;
            if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
            if ($urandom_range(0, 5) == 0) ins[12:9] = 4'b1010;
            run_instr(ins, 1'b0, 4'h0, lat);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
